// File: rtl/alu_mul_sequencer_if.sv
// ============================================================================
// Module      : alu_mul_sequencer_if
// Description : Bundle of the multiply request/response signals and the
//               shared-ALU borrow port used by alu_mul_sequencer.
//               master modport : core side (issues start, owns the ALU)
//               slave  modport : sequencer side
// Signals     : start, multiplicand, multiplier         core -> sequencer
//               busy, done, product_hi, product_lo      sequencer -> core
//               alu_req, alu_a, alu_b, alu_ic,
//               alu_opcode                              sequencer -> ALU
//               alu_gnt, alu_out, alu_oc                ALU/core -> sequencer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_mul_sequencer_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  start;
    logic [WORD_WIDTH-1:0] multiplicand;
    logic [WORD_WIDTH-1:0] multiplier;
    logic                  busy;
    logic                  done;
    logic [WORD_WIDTH-1:0] product_hi;
    logic [WORD_WIDTH-1:0] product_lo;
    logic                  alu_req;
    logic                  alu_gnt;
    logic [WORD_WIDTH-1:0] alu_a;
    logic [WORD_WIDTH-1:0] alu_b;
    logic                  alu_ic;
    logic [2:0]            alu_opcode;
    logic [WORD_WIDTH-1:0] alu_out;
    logic                  alu_oc;

    modport master (
        output start, multiplicand, multiplier, alu_gnt, alu_out, alu_oc,
        input  busy, done, product_hi, product_lo,
        input  alu_req, alu_a, alu_b, alu_ic, alu_opcode
    );

    modport slave (
        input  start, multiplicand, multiplier, alu_gnt, alu_out, alu_oc,
        output busy, done, product_hi, product_lo,
        output alu_req, alu_a, alu_b, alu_ic, alu_opcode
    );
endinterface

`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
// ============================================================================
// Module      : alu_mul_sequencer
// Description : Iterative unsigned shift-and-add multiplier that borrows the
//               core's shared ALU adder, one multiplier bit per step. The ALU
//               is requested only on steps whose current multiplier bit is 1;
//               a withheld grant stalls the sequencer for that cycle.
//               Optional feature macro: MUL_EARLY_EXIT_EN -- finish as soon as
//               all remaining multiplier bits are zero (same product).
// Ports       : clk      - rising-edge clock
//               reset_n  - asynchronous active-low reset
//               bus      - alu_mul_sequencer_if.slave (request, result and
//                          shared-ALU signals)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef OP_ADD
`define OP_ADD 3'd0
`endif

module alu_mul_sequencer #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_mul_sequencer_if.slave   bus
);

    localparam int CNT_W = $clog2(WORD_WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(WORD_WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]              state_q, state_d;
    logic [WORD_WIDTH-1:0]   mcand_q, mcand_d;
    logic [WORD_WIDTH-1:0]   hi_q, hi_d;
    logic [WORD_WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    w_alu_req;
    logic                    w_step;
    logic                    w_early;
    logic [2*WORD_WIDTH-1:0] w_shifted;

`ifdef MUL_EARLY_EXIT_EN
    // lo[cnt-1:0] are the multiplier bits not yet consumed; when they are all
    // zero the remaining steps would only shift, so do them in one go.
    logic [WORD_WIDTH-1:0]   w_rem_mask;
    assign w_rem_mask = ~({WORD_WIDTH{1'b1}} << cnt_q);
    assign w_early    = ((lo_q & w_rem_mask) == '0);
    assign w_shifted  = {hi_q, lo_q} >> cnt_q;
`else
    assign w_early    = 1'b0;
    assign w_shifted  = {hi_q, lo_q};
`endif

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        w_alu_req = 1'b0;
        w_step    = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (bus.start) begin
                    mcand_d = bus.multiplicand;
                    hi_d    = '0;
                    lo_d    = bus.multiplier;
                    cnt_d   = c_CNT_INIT;
                    state_d = c_RUN;
                end
            end

            c_RUN: begin
                if (w_early) begin
                    {hi_d, lo_d} = w_shifted;
                    cnt_d        = '0;
                    state_d      = c_DONE;
                end else begin
                    if (lo_q[0]) begin
                        // Add step: the ALU carry becomes the new top bit.
                        w_alu_req = 1'b1;
                        if (bus.alu_gnt) begin
                            {hi_d, lo_d} = {bus.alu_oc, bus.alu_out,
                                            lo_q[WORD_WIDTH-1:1]};
                            w_step       = 1'b1;
                        end
                    end else begin
                        {hi_d, lo_d} = {1'b0, hi_q, lo_q[WORD_WIDTH-1:1]};
                        w_step       = 1'b1;
                    end

                    if (w_step) begin
                        cnt_d = cnt_q - c_CNT_ONE;
                        if (cnt_q == c_CNT_ONE) begin
                            state_d = c_DONE;
                        end
                    end
                end
            end

            c_DONE: begin
                state_d = c_IDLE;
            end

            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    // The product registers are the working accumulator; they are stable from
    // DONE until the next accepted start.
    assign bus.busy       = (state_q != c_IDLE);
    assign bus.done       = (state_q == c_DONE);
    assign bus.product_hi = hi_q;
    assign bus.product_lo = lo_q;
    assign bus.alu_req    = w_alu_req;
    assign bus.alu_a      = mcand_q;
    assign bus.alu_b      = hi_q;
    assign bus.alu_ic     = 1'b0;
    assign bus.alu_opcode = `OP_ADD;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
// ============================================================================
// Module      : tb_alu_mul_sequencer
// Description : Self-checking bench for alu_mul_sequencer. Models the shared
//               ALU adder and a core that can withhold the grant for a chosen
//               number of requested cycles. Expected products are queued when
//               a multiply is started and popped when done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mul_sequencer;

    localparam int W     = 32;
    localparam int LIMIT = 200;

    logic clk;
    logic reset_n;

    alu_mul_sequencer_if #(.WORD_WIDTH(W)) bus ();

    alu_mul_sequencer #(.WORD_WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: plain 33-bit add.
    assign {bus.alu_oc, bus.alu_out} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}
                                       + {{W{1'b0}}, bus.alu_ic};

    // Core grant: deny requested cycles until deny_used catches up with
    // deny_budget.
    int deny_used   = 0;
    int deny_budget = 0;
    int req_cnt     = 0;
    assign bus.alu_gnt = (deny_used >= deny_budget);

    always @(posedge clk) begin
        if (bus.alu_req) begin
            req_cnt <= req_cnt + 1;
            if (!bus.alu_gnt) deny_used <= deny_used + 1;
        end
    end

    logic [2*W-1:0] sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Cycle in which done is expected, counting the start cycle as 0.
    function automatic int exp_latency(input logic [W-1:0] b, input int denies);
        int msb;
`ifdef MUL_EARLY_EXIT_EN
        if (b == '0) return 2 + denies;
        msb = 0;
        for (int i = 0; i < W; i++) if (b[i]) msb = i;
        if (msb == W - 1) return W + 1 + denies;
        return msb + 3 + denies;
`else
        msb = 0;
        return W + 1 + denies + msb;
`endif
    endfunction

    // Drive a start for one cycle at a negedge and queue the expected product.
    task automatic start_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int denies, output int req0);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        deny_budget      = deny_used + denies;
        req0             = req_cnt;
        sb.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
        @(negedge clk);
        bus.start        = 1'b0;
    endtask

    // Called at the negedge of cycle 1; returns the cycle index where done is
    // seen, or LIMIT if it never came.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!bus.done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    function automatic logic [2*W-1:0] pop_exp();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        n_checks += 5;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", bus.done); end
        if (bus.alu_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0b want 0", bus.alu_req); end
        if ({bus.product_hi, bus.product_lo} !== '0) begin
            n_fail++; $display("FAIL reset_product got %h want 0", {bus.product_hi, bus.product_lo});
        end
        if (bus.alu_ic !== 1'b0) begin n_fail++; $display("FAIL reset_alu_ic got %0b want 0", bus.alu_ic); end
    endtask

    // One multiply with full checking of latency, product, request count and
    // the one-cycle done pulse.
    task automatic test_mul(input string tag, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int denies);
        int req0, cyc, reqs;
        logic [2*W-1:0] exp_p;
        start_mul(a, b, denies, req0);
        wait_done(cyc);
        reqs  = req_cnt - req0;
        exp_p = pop_exp();
        n_checks += 5;
        if (cyc !== exp_latency(b, denies)) begin
            n_fail++; $display("FAIL %s_latency got %0d want %0d", tag, cyc, exp_latency(b, denies));
        end
        if ({bus.product_hi, bus.product_lo} !== exp_p) begin
            n_fail++; $display("FAIL %s_product got %h want %h", tag, {bus.product_hi, bus.product_lo}, exp_p);
        end
        if (reqs !== $countones(b) + denies) begin
            n_fail++; $display("FAIL %s_req_cycles got %0d want %0d", tag, reqs, $countones(b) + denies);
        end
        if (bus.alu_req !== 1'b0) begin
            n_fail++; $display("FAIL %s_req_in_done got %0b want 0", tag, bus.alu_req);
        end
        @(negedge clk);
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL %s_after_done got done=%0b busy=%0b want 0 0", tag, bus.done, bus.busy);
        end
    endtask

    task automatic test_start_ignored();
        int req0, cyc;
        logic [2*W-1:0] exp_p;
        start_mul(32'h0000_1234, 32'h0000_5678, 0, req0);
        repeat (4) @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = 32'h0000_DEAD;
        bus.multiplier   = 32'h0000_BEEF;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy_at_pulse got %0b want 1", bus.busy); end
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy_after_pulse got %0b want 1", bus.busy); end
        wait_done(cyc);
        cyc   = cyc + 5;
        exp_p = pop_exp();
        n_checks += 2;
        if (cyc !== exp_latency(32'h0000_5678, 0)) begin
            n_fail++; $display("FAIL ignore_latency got %0d want %0d", cyc, exp_latency(32'h0000_5678, 0));
        end
        if ({bus.product_hi, bus.product_lo} !== exp_p) begin
            n_fail++; $display("FAIL ignore_product got %h want %h", {bus.product_hi, bus.product_lo}, exp_p);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int req0;
        start_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, req0);
        repeat (9) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %0b want 1", bus.busy); end
        reset_n = 1'b0;
        sb.delete();
        #1;
        n_checks += 3;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %0b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %0b want 0", bus.done); end
        if ({bus.product_hi, bus.product_lo} !== '0) begin
            n_fail++; $display("FAIL midrst_product got %h want 0", {bus.product_hi, bus.product_lo});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL midrst_after_release got busy=%0b done=%0b want 0 0", bus.busy, bus.done);
        end
        test_mul("after_reset_5x6", 32'd5, 32'd6, 0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        int d;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
            d = $urandom_range(0, 3);
            n_checks++;
            if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_%0d got busy=%0b want 0", i, bus.busy); end
            test_mul($sformatf("b2b_%0d", i), a, b, d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        reset_n          = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();

        test_mul("ones_x_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        test_mul("7x3_gnt_high", 32'd7, 32'd3, 0);
        test_mul("7x3_two_denies", 32'd7, 32'd3, 2);
        test_start_ignored();
        test_reset_mid_run();
        test_mul("x_times_zero", 32'h1234_5678, 32'd0, 0);
        test_mul("msb_x_2", 32'h8000_0000, 32'd2, 0);
        test_mul("carry_ones_x_3", 32'hFFFF_FFFF, 32'd3, 0);
        test_mul("zero_x_ones", 32'd0, 32'hFFFF_FFFF, 1);
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
